// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL lock input and reset sequencing outputs bundle

interface pll_reset_sequencer_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 pll_lock_i;
    logic                 pll_reset_req_o;
    logic                 sys_rst_no;
    logic                 locked_o;
    logic [CNT_WIDTH-1:0] loss_cnt_o;

    // Sequencer side: consumes the raw lock, drives reset/request/status
    modport slave (
        input  pll_lock_i,
        output pll_reset_req_o,
        output sys_rst_no,
        output locked_o,
        output loss_cnt_o
    );

    // PLL / system side: drives the raw lock, observes the sequencer
    modport master (
        output pll_lock_i,
        input  pll_reset_req_o,
        input  sys_rst_no,
        input  locked_o,
        input  loss_cnt_o
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualification and system reset sequencer (optional loss counter: PLL_RESET_SEQ_LOSS_CNT_EN)

module pll_reset_sequencer #(
    parameter int SYNC_STAGES           = 2,
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int RST_HOLD_CYCLES       = 16,
    parameter int RELOCK_TIMEOUT_CYCLES = 65536,
    parameter int REQ_PULSE_CYCLES      = 4,
    parameter int CNT_WIDTH             = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    pll_reset_sequencer_if.slave  bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES),
                                  max2(RELOCK_TIMEOUT_CYCLES, REQ_PULSE_CYCLES));
    localparam int CW = $clog2(MAX_CYC + 1);

    // The WAIT_LOCK cycle that first sees lock_s=1 counts as the first of the
    // consecutive stable cycles, so STABLE itself ends one count earlier.
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 2);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(REQ_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_HOLD,
        ST_RUN,
        ST_REQ
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sys_rst_n_q;
    logic                   req_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Synchronize the asynchronous raw lock into clk_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock_i};
        end
    end

    // State, shared counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= (state_d == ST_RUN);
            req_q       <= (state_d == ST_REQ);
        end
    end

    // Next-state and counter logic; every exit to WAIT_LOCK restarts the timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.sys_rst_no      = sys_rst_n_q;
    assign bus.locked_o        = sys_rst_n_q;
    assign bus.pll_reset_req_o = req_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [CNT_WIDTH-1:0] loss_q;
    logic                 loss_evt;

    assign loss_evt = (state_q == ST_RUN) && !lock_s;

    // Count lock losses seen in RUN, holding at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != {CNT_WIDTH{1'b1}})) begin
            loss_q <= loss_q + CNT_WIDTH'(1);
        end
    end

    assign bus.loss_cnt_o = loss_q;
`else
    assign bus.loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed vector bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    pll_reset_sequencer_if #(.CNT_WIDTH(2)) bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES          (2),
        .LOCK_STABLE_CYCLES   (8),
        .RST_HOLD_CYCLES      (4),
        .RELOCK_TIMEOUT_CYCLES(32),
        .REQ_PULSE_CYCLES     (4),
        .CNT_WIDTH            (2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string name;
        logic  lock;
        int    edges;
        logic  exp_sys;
        logic  exp_req;
        int    exp_loss;
    } vec_t;

    vec_t vecs[$];

    function automatic int lossv(input int n);
        int v;
        v = (n > 3) ? 3 : n;
        return LOSS_EN ? v : 0;
    endfunction

    function automatic void add(input string nm, input logic lk, input int ed,
                                input logic es, input logic er, input int el);
        vec_t v;
        v.name = nm; v.lock = lk; v.edges = ed;
        v.exp_sys = es; v.exp_req = er; v.exp_loss = el;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic es, input logic er, input int el);
        chk({nm, ".sys_rst_no"}, int'(bus.sys_rst_no), int'(es));
        chk({nm, ".locked_o"}, int'(bus.locked_o), int'(es));
        chk({nm, ".pll_reset_req_o"}, int'(bus.pll_reset_req_o), int'(er));
        chk({nm, ".loss_cnt_o"}, int'(bus.loss_cnt_o), el);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Qualification from reset, then five losses in RUN
        add("rise_e13", 1'b1, 13, 1'b0, 1'b0, 0);
        add("rise_e14", 1'b1, 1,  1'b1, 1'b0, 0);
        for (int k = 1; k <= 4; k++) begin
            add("drop_e2",   1'b0, 2,  1'b1, 1'b0, lossv(k - 1));
            add("drop_e3",   1'b0, 1,  1'b0, 1'b0, lossv(k));
            add("requal_13", 1'b1, 13, 1'b0, 1'b0, lossv(k));
            add("requal_14", 1'b1, 1,  1'b1, 1'b0, lossv(k));
        end
        add("drop5_e2", 1'b0, 2, 1'b1, 1'b0, lossv(4));
        add("drop5_e3", 1'b0, 1, 1'b0, 1'b0, lossv(5));
        // Lock high 5, low 1, high again: qualification restarts
        add("short_hi5",  1'b1, 5,  1'b0, 1'b0, lossv(5));
        add("short_lo1",  1'b0, 1,  1'b0, 1'b0, lossv(5));
        add("rerise_13",  1'b1, 13, 1'b0, 1'b0, lossv(5));
        add("rerise_14",  1'b1, 1,  1'b1, 1'b0, lossv(5));
        // Lose lock for good: timeout and repeating request pulses
        add("final_drop", 1'b0, 3,  1'b0, 1'b0, lossv(6));
        add("to_pre",     1'b0, 31, 1'b0, 1'b0, lossv(6));
        add("req1_rise",  1'b0, 1,  1'b0, 1'b1, lossv(6));
        add("req1_last",  1'b0, 3,  1'b0, 1'b1, lossv(6));
        add("req1_fall",  1'b0, 1,  1'b0, 1'b0, lossv(6));
        add("to2_pre",    1'b0, 31, 1'b0, 1'b0, lossv(6));
        add("req2_rise",  1'b0, 1,  1'b0, 1'b1, lossv(6));

        rst_n = 1'b0;
        bus.pll_lock_i = 1'b0;
        step(3);
        chk_all("reset", 1'b0, 1'b0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.pll_lock_i = vecs[i].lock;
            step(vecs[i].edges);
            chk_all(vecs[i].name, vecs[i].exp_sys, vecs[i].exp_req, vecs[i].exp_loss);
        end

        // Second cycle of the request pulse, then asynchronous reset
        step(1);
        chk("req_cycle2", int'(bus.pll_reset_req_o), 1);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 0);
        bus.pll_lock_i = 1'b1;
        step(2);
        chk_all("rst_held", 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        step(13);
        chk_all("post_rst_e13", 1'b0, 1'b0, 0);
        step(1);
        chk_all("post_rst_e14", 1'b1, 1'b0, 0);

        // Sub-cycle lock glitches between edges are never sampled
        for (int g = 0; g < 5; g++) begin
            bus.pll_lock_i = 1'b0;
            #2;
            bus.pll_lock_i = 1'b1;
            step(1);
        end
        step(3);
        chk_all("glitch_ignored", 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, 2, flops in the pll_lock_i synchronizer chain (min 2).
REQ-002 Parameter LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before the hold phase.
REQ-003 Parameter RST_HOLD_CYCLES, 16, cycles system reset is held after lock is qualified.
REQ-004 Parameter RELOCK_TIMEOUT_CYCLES, 65536, cycles without lock before the PLL re-init is requested.
REQ-005 Parameter REQ_PULSE_CYCLES, 4, width of the pll_reset_req_o pulse.
REQ-006 Parameter CNT_WIDTH, 8, width of loss_cnt_o.
REQ-007 clk_i  input  1  free-running reference clock, same clock as the PLL init logic; not a PLL output.
REQ-008 rst_ni  input  1  asynchronous, active-low reset.
REQ-009 pll_lock_i  input  1  raw PLL lock; asynchronous to clk_i.
REQ-010 pll_reset_req_o  output  1  registered request to the PLL init logic to re-run PLL reset.
REQ-011 sys_rst_no  output  1  registered, active-low system reset for downstream logic.
REQ-012 locked_o  output  1  high only in RUN.
REQ-013 loss_cnt_o  output  CNT_WIDTH  saturating count of lock-loss events seen in RUN.

Function
REQ-014 pll_lock_i SHALL pass through SYNC_STAGES flops; the FSM SHALL use only the last stage (lock_s).
REQ-015 FSM states SHALL be WAIT_LOCK, STABLE, HOLD, RUN, REQ; one shared down/up counter, wide enough for the largest parameter.
REQ-016 WAIT_LOCK: lock_s=1 -> STABLE with counter cleared; else counter increments; on reaching RELOCK_TIMEOUT_CYCLES -> REQ.
REQ-017 STABLE: lock_s=0 -> WAIT_LOCK (timeout counter restarts at 0); LOCK_STABLE_CYCLES consecutive lock_s=1 cycles -> HOLD.
REQ-018 HOLD: lock_s=0 -> WAIT_LOCK; after RST_HOLD_CYCLES -> RUN.
REQ-019 RUN: lock_s=0 -> WAIT_LOCK and loss_cnt_o increments by 1, saturating at all-ones.
REQ-020 REQ: pll_reset_req_o=1 for exactly REQ_PULSE_CYCLES cycles, then -> WAIT_LOCK with counter cleared; lock_s ignored during REQ.
REQ-021 sys_rst_no SHALL be 1 only while the registered state is RUN; locked_o SHALL equal sys_rst_no inverted-polarity-free (locked_o = sys_rst_no).
REQ-022 Latency: with lock steady high, sys_rst_no rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES, counting the first edge that samples pll_lock_i=1 as edge 1.
REQ-023 Lock loss in RUN: sys_rst_no falls at edge SYNC_STAGES+1 after the first edge sampling pll_lock_i=0.
REQ-024 Lock glitches shorter than one clk_i period SHALL either be ignored or restart qualification; never produce a partial-cycle reset.

Reset
REQ-025 While rst_ni=0: state WAIT_LOCK, counter 0, sync chain 0, sys_rst_no=0, locked_o=0, pll_reset_req_o=0, loss_cnt_o=0.
REQ-026 Reset assertion mid-REQ SHALL terminate the pulse immediately; deassertion restarts qualification from WAIT_LOCK.

Configuration
REQ-027 Macro PLL_RESET_SEQ_LOSS_CNT_EN: defined -> loss counter per REQ-019; undefined -> no counter flops, loss_cnt_o tied to 0.

Verification (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, RELOCK_TIMEOUT_CYCLES=32, REQ_PULSE_CYCLES=4, CNT_WIDTH=2)
REQ-028 Release rst_ni, raise pll_lock_i -> sys_rst_no and locked_o rise at edge 14, pll_reset_req_o stays 0.
REQ-029 Lock held 5 cycles then dropped 1 cycle then high -> qualification restarts; sys_rst_no rises 14 edges after re-rise.
REQ-030 pll_lock_i held 0 -> pll_reset_req_o high 4 cycles starting after 32 WAIT_LOCK cycles, repeating every 36 cycles.
REQ-031 In RUN, drop lock 5 times with requalification between -> sys_rst_no low 3 edges after each drop; loss_cnt_o reads 1,2,3,3,3 (0 with macro undefined).
REQ-032 Assert rst_ni during REQ pulse cycle 2 -> pll_reset_req_o and all outputs 0 asynchronously; loss_cnt_o cleared.
